// File: rtl/bip_pkg.sv
// Shared encodings for the parametrised BIP accumulator core: opcodes, FSM states,
// datapath select codes and the decoded control word.
package bip_pkg;

    localparam int OPC_W_DEF = 5;

    localparam logic [OPC_W_DEF-1:0] OP_HLT  = 5'b00000;
    localparam logic [OPC_W_DEF-1:0] OP_STO  = 5'b00001;
    localparam logic [OPC_W_DEF-1:0] OP_LD   = 5'b00010;
    localparam logic [OPC_W_DEF-1:0] OP_LDI  = 5'b00011;
    localparam logic [OPC_W_DEF-1:0] OP_ADD  = 5'b00100;
    localparam logic [OPC_W_DEF-1:0] OP_ADDI = 5'b00101;
    localparam logic [OPC_W_DEF-1:0] OP_SUB  = 5'b00110;
    localparam logic [OPC_W_DEF-1:0] OP_SUBI = 5'b00111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SEL_A_MEM = 2'd0,
        SEL_A_IMM = 2'd1,
        SEL_A_ALU = 2'd2
    } sel_a_t;

    typedef enum logic {
        SEL_B_MEM = 1'b0,
        SEL_B_IMM = 1'b1
    } sel_b_t;

    typedef enum logic {
        ALU_ADD = 1'b0,
        ALU_SUB = 1'b1
    } alu_op_t;

    typedef struct packed {
        logic    wr_pc;
        logic    wr_acc;
        sel_a_t  sel_a;
        sel_b_t  sel_b;
        alu_op_t alu_op;
        logic    wr_ram;
        logic    is_hlt;
    } ctrl_t;

endpackage

// File: rtl/bip_decoder.sv
// Combinational BIP opcode decoder; unknown opcodes decode to a NOP that only advances the PC.
module bip_decoder
    import bip_pkg::*;
#(
    parameter int OPC_W = 5
) (
    input  logic [OPC_W-1:0] opcode,
    output ctrl_t            ctrl
);

    always_comb begin
        // NOTE: every field gets a default before the case so no path leaves a latch behind.
        ctrl.wr_pc  = 1'b1;
        ctrl.wr_acc = 1'b0;
        ctrl.sel_a  = SEL_A_ALU;
        ctrl.sel_b  = SEL_B_MEM;
        ctrl.alu_op = ALU_ADD;
        ctrl.wr_ram = 1'b0;
        ctrl.is_hlt = 1'b0;

        case (opcode)
            OPC_W'(OP_HLT): begin
                ctrl.wr_pc  = 1'b0;
                ctrl.is_hlt = 1'b1;
            end
            OPC_W'(OP_STO): ctrl.wr_ram = 1'b1;
            OPC_W'(OP_LD): begin
                ctrl.wr_acc = 1'b1;
                ctrl.sel_a  = SEL_A_MEM;
            end
            OPC_W'(OP_LDI): begin
                ctrl.wr_acc = 1'b1;
                ctrl.sel_a  = SEL_A_IMM;
            end
            OPC_W'(OP_ADD): ctrl.wr_acc = 1'b1;
            OPC_W'(OP_ADDI): begin
                ctrl.wr_acc = 1'b1;
                ctrl.sel_b  = SEL_B_IMM;
            end
            OPC_W'(OP_SUB): begin
                ctrl.wr_acc = 1'b1;
                ctrl.alu_op = ALU_SUB;
            end
            OPC_W'(OP_SUBI): begin
                ctrl.wr_acc = 1'b1;
                ctrl.sel_b  = SEL_B_IMM;
                ctrl.alu_op = ALU_SUB;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/bip_core_param.sv
// Parametrised BIP accumulator core: IDLE/RUN/HALT controller, PC, accumulator, ALU and a
// saturating RUN-cycle counter. Instruction and data memories live outside this block.
module bip_core_param
    import bip_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 11,
    parameter int OPC_W  = 5,
    parameter int CNT_W  = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    output logic [ADDR_W-1:0]       instr_addr,
    input  logic [OPC_W+ADDR_W-1:0] instr_data,
    output logic [ADDR_W-1:0]       dmem_addr,
    output logic [DATA_W-1:0]       dmem_wdata,
    output logic                    dmem_we,
    input  logic [DATA_W-1:0]       dmem_rdata,
    output logic [DATA_W-1:0]       acumulador,
    output logic [7:0]              led_acc,
    output logic [CNT_W-1:0]        clk_count,
    output logic                    running,
    output logic                    halted
);

    localparam int INSTR_W = OPC_W + ADDR_W;

    state_t            state, state_nxt;
    ctrl_t             ctrl;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] acc, acc_nxt, imm, alu_b, alu_res;
    logic [CNT_W-1:0]  cnt;
    logic [OPC_W-1:0]  opcode;
    logic [ADDR_W-1:0] operand;
    logic              run;

    assign opcode  = instr_data[INSTR_W-1 -: OPC_W];
    assign operand = instr_data[ADDR_W-1:0];
    assign imm     = DATA_W'($signed(operand));
    assign run     = (state == ST_RUN);

    bip_decoder #(.OPC_W(OPC_W)) u_decoder (
        .opcode (opcode),
        .ctrl   (ctrl)
    );

    // Single adder/subtractor; results wrap modulo 2^DATA_W.
    assign alu_b   = (ctrl.sel_b == SEL_B_IMM) ? imm : dmem_rdata;
    assign alu_res = (ctrl.alu_op == ALU_SUB) ? (acc - alu_b) : (acc + alu_b);

    always_comb begin
        case (ctrl.sel_a)
            SEL_A_MEM: acc_nxt = dmem_rdata;
            SEL_A_IMM: acc_nxt = imm;
            default:   acc_nxt = alu_res;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start)       state_nxt = ST_RUN;
            ST_RUN:  if (ctrl.is_hlt) state_nxt = ST_HALT;
            ST_HALT: state_nxt = ST_HALT;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            pc    <= '0;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values, as the hardware does.
            state <= state_nxt;
            if (run) begin
                if (cnt != {CNT_W{1'b1}}) cnt <= cnt + CNT_W'(1);
                if (ctrl.wr_pc)           pc  <= pc + ADDR_W'(1);
                if (ctrl.wr_acc)          acc <= acc_nxt;
            end
        end
    end

    assign instr_addr = pc;
    assign dmem_addr  = operand;
    assign dmem_wdata = acc;
    assign dmem_we    = run & ctrl.wr_ram;
    assign acumulador = acc;
    assign led_acc    = acc[7:0];
    assign clk_count  = cnt;
    assign running    = run;
    assign halted     = (state == ST_HALT);

endmodule

// File: tb/tb_bip_core_param.sv
// Directed self-checking bench for bip_core_param: a 16-bit default instance and a
// 32-bit/4-bit-counter instance, each with its own behavioural instruction/data memory.
module tb_bip_core_param;

    localparam int AW = 11;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start0 = 1'b0;
    logic start1 = 1'b0;
    logic mem_clr = 1'b1;

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // ---------------- instance 0: DATA_W=16, CNT_W=8 ----------------
    logic [15:0] imem0 [DEPTH];
    logic [15:0] dmem0 [DEPTH];
    logic [AW-1:0] iaddr0, daddr0;
    logic [15:0] idata0, wdata0, rdata0, acc0;
    logic we0, run0, hlt0;
    logic [7:0] led0, cnt0;
    int wr10_cnt;
    logic we_seen0;

    assign idata0 = imem0[iaddr0];
    assign rdata0 = dmem0[daddr0];

    bip_core_param #(.DATA_W(16), .ADDR_W(AW), .OPC_W(5), .CNT_W(8)) u_dut0 (
        .clk(clk), .reset(reset), .start(start0),
        .instr_addr(iaddr0), .instr_data(idata0),
        .dmem_addr(daddr0), .dmem_wdata(wdata0), .dmem_we(we0), .dmem_rdata(rdata0),
        .acumulador(acc0), .led_acc(led0), .clk_count(cnt0),
        .running(run0), .halted(hlt0)
    );

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < DEPTH; i++) dmem0[i] <= '0;
            wr10_cnt <= 0;
            we_seen0 <= 1'b0;
        end else if (we0) begin
            dmem0[daddr0] <= wdata0;
            we_seen0 <= 1'b1;
            if (daddr0 == AW'(10)) wr10_cnt <= wr10_cnt + 1;
        end
    end

    // ---------------- instance 1: DATA_W=32, CNT_W=4 ----------------
    logic [15:0] imem1 [DEPTH];
    logic [31:0] dmem1 [DEPTH];
    logic [AW-1:0] iaddr1, daddr1;
    logic [15:0] idata1;
    logic [31:0] wdata1, rdata1, acc1;
    logic we1, run1, hlt1;
    logic [7:0] led1;
    logic [3:0] cnt1;
    logic we_seen1;

    assign idata1 = imem1[iaddr1];
    assign rdata1 = dmem1[daddr1];

    bip_core_param #(.DATA_W(32), .ADDR_W(AW), .OPC_W(5), .CNT_W(4)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1),
        .instr_addr(iaddr1), .instr_data(idata1),
        .dmem_addr(daddr1), .dmem_wdata(wdata1), .dmem_we(we1), .dmem_rdata(rdata1),
        .acumulador(acc1), .led_acc(led1), .clk_count(cnt1),
        .running(run1), .halted(hlt1)
    );

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < DEPTH; i++) dmem1[i] <= '0;
            we_seen1 <= 1'b0;
        end else if (we1) begin
            dmem1[daddr1] <= wdata1;
            we_seen1 <= 1'b1;
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ins(input logic [4:0] op, input logic [10:0] arg);
        return {op, arg};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill0(input logic [15:0] v);
        for (int i = 0; i < DEPTH; i++) imem0[i] = v;
    endtask

    task automatic fill1(input logic [15:0] v);
        for (int i = 0; i < DEPTH; i++) imem1[i] = v;
    endtask

    // Called between edges: asynchronous reset pulse shorter than half a period.
    task automatic pulse_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    task automatic go0();
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
    endtask

    task automatic go1();
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
    endtask

    task automatic load_main_prog();
        fill0(16'h0000);
        imem0[0] = ins(5'b00011, 11'd5);   // LDI 5
        imem0[1] = ins(5'b00101, 11'd3);   // ADDI 3
        imem0[2] = ins(5'b00001, 11'd10);  // STO 10
        imem0[3] = ins(5'b00111, 11'd1);   // SUBI 1
        imem0[4] = ins(5'b00010, 11'd10);  // LD 10
        imem0[5] = ins(5'b00000, 11'd0);   // HLT
    endtask

    task automatic run_main_prog(input string pfx);
        logic [15:0] exp_acc [5];
        exp_acc = '{16'd5, 16'd8, 16'd8, 16'd7, 16'd8};
        go0();
        check({pfx, "_start_edge_pc"}, 64'(iaddr0), 64'd0);
        check({pfx, "_start_edge_running"}, 64'(run0), 64'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("%s_acc_step%0d", pfx, i), 64'(acc0), 64'(exp_acc[i]));
        end
        tick();
        check({pfx, "_halted"}, 64'(hlt0), 64'd1);
        check({pfx, "_running_off"}, 64'(run0), 64'd0);
        check({pfx, "_clk_count"}, 64'(cnt0), 64'd6);
        check({pfx, "_led_acc"}, 64'(led0), 64'h08);
        check({pfx, "_pc"}, 64'(iaddr0), 64'd5);
        check({pfx, "_mem10"}, 64'(dmem0[10]), 64'd8);
    endtask

    initial begin
        load_main_prog();
        fill1(16'h0000);
        tick();
        tick();
        reset = 1'b0;
        mem_clr = 1'b0;

        // Idle after reset: nothing moves, no writes.
        repeat (5) tick();
        check("idle_pc", 64'(iaddr0), 64'd0);
        check("idle_acc", 64'(acc0), 64'd0);
        check("idle_cnt", 64'(cnt0), 64'd0);
        check("idle_running", 64'(run0), 64'd0);
        check("idle_halted", 64'(hlt0), 64'd0);
        check("idle_we_seen", 64'(we_seen0), 64'd0);

        // Main program.
        run_main_prog("prog");
        check("prog_mem10_writes", 64'(wr10_cnt), 64'd1);

        // HALT freezes everything despite start toggling.
        for (int i = 0; i < 20; i++) begin
            start0 = i[0];
            tick();
        end
        start0 = 1'b0;
        check("halt_acc", 64'(acc0), 64'd8);
        check("halt_pc", 64'(iaddr0), 64'd5);
        check("halt_cnt", 64'(cnt0), 64'd6);
        check("halt_halted", 64'(hlt0), 64'd1);
        check("halt_mem10_writes", 64'(wr10_cnt), 64'd1);

        // Sign extension and modulo arithmetic.
        pulse_reset();
        fill0(16'h0000);
        imem0[0] = ins(5'b00011, 11'h7FF);  // LDI 0x7FF -> -1
        imem0[1] = ins(5'b00101, 11'd1);    // ADDI 1
        imem0[2] = ins(5'b00111, 11'd1);    // SUBI 1
        check("rst_acc", 64'(acc0), 64'd0);
        go0();
        tick();
        check("sext_ldi", 64'(acc0), 64'hFFFF);
        tick();
        check("wrap_addi", 64'(acc0), 64'h0000);
        tick();
        check("wrap_subi", 64'(acc0), 64'hFFFF);
        tick();
        check("sext_halted", 64'(hlt0), 64'd1);

        // All-NOP memory: counter saturates, PC wraps.
        pulse_reset();
        fill0(16'hF800);
        go0();
        repeat (2047) tick();
        check("nop_pc_top", 64'(iaddr0), 64'd2047);
        check("nop_cnt_sat", 64'(cnt0), 64'd255);
        check("nop_running", 64'(run0), 64'd1);
        tick();
        check("nop_pc_wrap", 64'(iaddr0), 64'd0);
        check("nop_cnt_hold", 64'(cnt0), 64'd255);
        check("nop_acc", 64'(acc0), 64'd0);

        // Asynchronous reset mid-run, then re-run from pc=0.
        pulse_reset();
        load_main_prog();
        go0();
        repeat (3) tick();
        check("mid_acc", 64'(acc0), 64'd8);
        check("mid_cnt", 64'(cnt0), 64'd3);
        reset = 1'b1;
        #1;
        check("async_pc", 64'(iaddr0), 64'd0);
        check("async_acc", 64'(acc0), 64'd0);
        check("async_cnt", 64'(cnt0), 64'd0);
        check("async_running", 64'(run0), 64'd0);
        check("async_halted", 64'(hlt0), 64'd0);
        check("async_we", 64'(we0), 64'd0);
        reset = 1'b0;
        tick();
        check("post_rst_idle", 64'(run0), 64'd0);
        run_main_prog("rerun");

        // 32-bit data path with a 4-bit counter.
        imem1[0] = ins(5'b00011, 11'd0);  // LDI 0
        imem1[1] = ins(5'b00111, 11'd1);  // SUBI 1
        imem1[2] = ins(5'b00000, 11'd0);  // HLT
        go1();
        repeat (3) tick();
        check("w32_acc", 64'(acc1), 64'hFFFF_FFFF);
        check("w32_cnt", 64'(cnt1), 64'd3);
        check("w32_halted", 64'(hlt1), 64'd1);
        check("w32_led", 64'(led1), 64'hFF);

        pulse_reset();
        fill1(16'hF800);
        imem1[20] = ins(5'b00000, 11'd0);
        go1();
        repeat (21) tick();
        check("w32_nop_halted", 64'(hlt1), 64'd1);
        check("w32_cnt_sat", 64'(cnt1), 64'd15);
        check("w32_nop_pc", 64'(iaddr1), 64'd20);
        check("w32_we_seen", 64'(we_seen1), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bip_core_param.md
Name: bip_core_param

Overview:
- Parametrised successor of the fixed 16-bit BIP accumulator processor.
- Executes one BIP instruction per clock after a `start` strobe and stops on HLT.
- Width of data, address and cycle counter are set by parameters; instruction and data memories are external.
- Adds running/halted status, a saturating cycle counter and an explicit IDLE/RUN/HALT controller; sits below the board-level TOP, which owns the memories and LEDs.

Parameters:
- DATA_W, 16, accumulator and data-memory word width; must be >= ADDR_W and >= 8.
- ADDR_W, 11, operand, PC and memory address width.
- OPC_W, 5, opcode width; instruction word width = OPC_W+ADDR_W.
- CNT_W, 8, cycle-counter width.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  run request, sampled on rising clk.
- instr_addr  out  ADDR_W  PC, drives instruction memory address.
- instr_data  in  OPC_W+ADDR_W  instruction at instr_addr, combinational read: opcode in MSBs, operand in LSBs.
- dmem_addr  out  ADDR_W  data memory address, equals the current operand.
- dmem_wdata  out  DATA_W  write data, equals the accumulator.
- dmem_we  out  1  data memory write enable, written on rising clk.
- dmem_rdata  in  DATA_W  combinational read of dmem_addr.
- acumulador  out  DATA_W  accumulator.
- led_acc  out  8  acumulador[7:0].
- clk_count  out  CNT_W  cycles spent in RUN.
- running  out  1  state==RUN.
- halted  out  1  state==HALT.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high.
  - While reset=1: state=IDLE, pc=0, acumulador=0, clk_count=0, dmem_we=0, running=0, halted=0.
  - Reset asserted mid-run clears everything immediately, without waiting for an edge.
- FSM:
  - IDLE: pc, acc and count hold. Go to RUN on the first rising edge with start=1; no instruction executes on that edge.
  - RUN: one instruction is executed per rising edge. start is ignored.
  - HLT executed in RUN: go to HALT; pc and acc unchanged.
  - HALT: all registers frozen, start ignored, exit only by reset.
- Instruction set (opcode, effect). All non-HLT opcodes do pc <= pc+1.
  - 00000 HLT.
  - 00001 STO: mem[op] <= acc. dmem_we=1 combinationally during that RUN cycle only.
  - 00010 LD: acc <= mem[op].
  - 00011 LDI: acc <= sext(op).
  - 00100 ADD: acc <= acc+mem[op].
  - 00101 ADDI: acc <= acc+sext(op).
  - 00110 SUB: acc <= acc-mem[op].
  - 00111 SUBI: acc <= acc-sext(op).
  - Any other opcode: NOP.
- Arithmetic:
  - sext sign-extends the ADDR_W operand to DATA_W.
  - Add and subtract are modulo 2^DATA_W; no flags.
- PC wrap-around: 2^ADDR_W-1 wraps to 0.
- dmem_we is 0 outside RUN and for every opcode except STO.
- clk_count:
  - Increments on every rising edge taken while in RUN, including the HLT edge, so a program of N instructions plus HLT yields N+1.
  - Saturates at 2^CNT_W-1 and does not wrap.
- Latency: the result of an instruction is visible on acumulador immediately after the executing edge. LD after STO to the same address returns the stored value.

Decomposition:
- Package bip_pkg holds:
  - opcode localparams (OP_HLT..OP_SUBI);
  - FSM state encoding (ST_IDLE, ST_RUN, ST_HALT);
  - ALU-op and operand-select encodings.
- One sub-module, bip_decoder: combinational opcode -> {wr_pc, wr_acc, sel_a (mem/imm/alu), sel_b (mem/imm), alu_op add/sub, wr_ram, is_hlt}.
- bip_core_param keeps the FSM, pc, acc, ALU and counter.

Test Plan:
- Reset, then start=0 for 5 cycles -> pc=0, acumulador=0, clk_count=0, running=0, halted=0, dmem_we never 1.
- Program LDI 5; ADDI 3; STO 10; SUBI 1; LD 10; HLT, then start=1 -> acc after each edge 5, 8, 8, 7, 8.
  - mem[10]=8, written exactly once.
  - Final state: halted=1, clk_count=6, led_acc=0x08, pc=5.
  - Afterwards acc and pc stay frozen for 20 more cycles with start toggling.
- LDI 0x7FF; ADDI 1; SUBI 1 -> acc 0xFFFF, 0x0000, 0xFFFF (sign extension and wrap).
- Memory filled with opcode 11111 (NOP) -> clk_count stops at 255; pc goes 2047 -> 0 on the 2048th RUN edge; acc stays 0.
- Reset pulsed between edges after 3 RUN cycles -> all outputs 0 before the next edge, state IDLE; a new start re-runs the program from pc=0 with identical results.
- DATA_W=32, CNT_W=4: LDI 0; SUBI 1; HLT -> acc=0xFFFFFFFF, clk_count=3.
  - With 20 NOPs before HLT: clk_count saturates at 15.
